// File: rtl/adiv_pkg.sv
// rtl/adiv_pkg.sv - shared types and approximation profile table for the sequential divider
// Purpose: state enum, approximation mode constants and the per-iteration
//          approximate-cell count lookup used by approx_div_seq_ctrl.
package adiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adiv_state_e;

  localparam logic [1:0] ADIV_EXACT = 2'd0;
  localparam logic [1:0] ADIV_AD2   = 2'd1;
  localparam logic [1:0] ADIV_AGGR  = 2'd2;

  // Number of LSB cells (0..2) of the row that use the approximate cell
  // for a given profile and iteration (iteration 0 is the quotient MSB).
  // Mode 3 is reserved and falls through to the exact profile.
  function automatic logic [1:0] approx_cells(input logic [1:0] mode, input logic [2:0] iter);
    logic [1:0] n;
    n = 2'd0;
    case (mode)
      ADIV_EXACT: n = 2'd0;
      ADIV_AD2: begin
        if (iter == 3'd6)      n = 2'd1;
        else if (iter == 3'd7) n = 2'd2;
        else                   n = 2'd0;
      end
      ADIV_AGGR: n = iter[2] ? 2'd2 : 2'd0;
      default:   n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/adiv_sub_row.sv
// rtl/adiv_sub_row.sv - combinational 9-bit restoring subtract/select row
// Purpose: one restoring-division row; the lowest ncell bit positions use the
//          approximate cell, the remaining positions use the exact cell.
// Ports:
//   x[8:0]     row input {partial remainder, next dividend bit}
//   y[7:0]     divisor
//   ncell[1:0] number of approximate LSB cells (0..2)
//   qs         quotient bit produced by this row
//   rout[7:0]  next partial remainder
module adiv_sub_row (
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic [1:0] ncell,
  output logic       qs,
  output logic [7:0] rout
);

  logic [7:0] bin_v;
  logic [7:0] bout_v;
  logic [7:0] apx_v;

  always_comb begin
    logic br;
    br     = 1'b0;  // row borrow-in is tied low
    bin_v  = '0;
    bout_v = '0;
    apx_v  = '0;
    for (int i = 0; i < 8; i++) begin
      apx_v[i] = (i < int'(ncell));
      bin_v[i] = br;
      if (apx_v[i]) begin
        bout_v[i] = br | y[i];
      end else begin
        bout_v[i] = (~x[i] & br) | (~x[i] & y[i]) | (y[i] & br);
      end
      br = bout_v[i];
    end
  end

  // x[8] set means the 9-bit row value is at least 256, so it always exceeds y.
  assign qs = ~bout_v[7] | x[8];

  always_comb begin
    rout = '0;
    for (int i = 0; i < 8; i++) begin
      if (apx_v[i]) begin
        rout[i] = qs ? x[i] : ~y[i];
      end else begin
        rout[i] = qs ? (x[i] ^ y[i] ^ bin_v[i]) : x[i];
      end
    end
  end

endmodule

// File: rtl/approx_div_seq_ctrl.sv
// rtl/approx_div_seq_ctrl.sv - sequential 16/8 approximate restoring divider controller
// Purpose: accepts a command on a valid/ready handshake, iterates one shared
//          subtract/select row for 8 cycles, and presents the result on a
//          valid/ready handshake. Optional overflow flag: ADIV_OVF_CHECK_EN.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      command handshake (in_ready high only in IDLE)
//   dividend, divisor        operands sampled on the command handshake
//   approx_mode              approximation profile sampled on the handshake
//   out_valid / out_ready    result handshake
//   quotient, remainder      result, held stable while out_valid is high
//   ovf                      dividend[15:8] >= divisor (0 unless ADIV_OVF_CHECK_EN)
module approx_div_seq_ctrl
  import adiv_pkg::*;
#(
  parameter int DW = 16,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [YW-1:0] divisor,
  input  logic [1:0]    approx_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [YW-1:0] quotient,
  output logic [YW-1:0] remainder,
  output logic          ovf
);

  adiv_state_e   state;
  logic [YW-1:0] rem;
  logic [YW-1:0] dq;    // unconsumed dividend bits shift out MSB-first, quotient bits shift in
  logic [YW-1:0] dsr;
  logic [1:0]    mode;
  logic [2:0]    iter;

  logic          row_qs;
  logic [YW-1:0] row_rout;
  logic [1:0]    row_ncell;

  assign row_ncell = approx_cells(mode, iter);

  adiv_sub_row u_row (
    .x     ({rem, dq[YW-1]}),
    .y     (dsr),
    .ncell (row_ncell),
    .qs    (row_qs),
    .rout  (row_rout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      rem       <= '0;
      dq        <= '0;
      dsr       <= '0;
      mode      <= 2'd0;
      iter      <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem      <= dividend[DW-1:YW];
            dq       <= dividend[YW-1:0];
            dsr      <= divisor;
            mode     <= approx_mode;
            iter     <= 3'd0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          rem  <= row_rout;
          dq   <= {dq[YW-2:0], row_qs};
          iter <= iter + 3'd1;
          if (iter == 3'd7) begin
            // Load the result registers from the final row directly so the
            // outputs are valid in the same cycle out_valid rises.
            quotient  <= {dq[YW-2:0], row_qs};
            remainder <= row_rout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADIV_OVF_CHECK_EN
  logic ovf_r;
  logic ovf_q;

  // The comparison is captured at acceptance but only exposed alongside the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        ovf_r <= (dividend[DW-1:YW] >= divisor);
      end
      if (state == RUN && iter == 3'd7) begin
        ovf_q <= ovf_r;
      end else if (state == DONE && out_ready) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_approx_div_seq_ctrl.sv
// tb/tb_approx_div_seq_ctrl.sv - self-checking bench for approx_div_seq_ctrl
module tb_approx_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = 16'h0;
  logic [7:0]  divisor = 8'h0;
  logic [1:0]  approx_mode = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  int          cyc = 0;
  int          acc = 0;
  logic        pending = 1'b0;
  logic [7:0]  eq = 8'h0;
  logic [7:0]  er = 8'h0;
  logic        eovf = 1'b0;

  approx_div_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .approx_mode (approx_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  // Approximate LSB cell count per iteration, straight from the profile table.
  function automatic int ncell(input int m, input int it);
    case (m)
      1:       return (it == 6) ? 1 : ((it == 7) ? 2 : 0);
      2:       return (it >= 4) ? 2 : 0;
      default: return 0;
    endcase
  endfunction

  // Arithmetic model: the exact upper cells form an ordinary subtraction whose
  // borrow-in is the OR of the divisor's low bits (approximate borrow chain).
  function automatic logic [15:0] model(input logic [15:0] dd, input logic [7:0] y, input logic [1:0] m);
    int rem, dq, q, x, xl, k, mask, yl, d, qs;
    rem = int'(dd[15:8]);
    dq  = int'(dd[7:0]);
    yl  = int'(y);
    q   = 0;
    for (int it = 0; it < 8; it++) begin
      k    = ncell(int'(m), it);
      mask = (1 << k) - 1;
      x    = rem * 2 + ((dq >> 7) & 1);
      dq   = (dq << 1) & 255;
      xl   = x & 255;
      d    = (xl >> k) - (yl >> k) - (((yl & mask) != 0) ? 1 : 0);
      qs   = (d >= 0 || x >= 256) ? 1 : 0;
      if (qs != 0) rem = ((d & (255 >> k)) << k) | (xl & mask);
      else         rem = (xl & ~mask) | (~yl & mask);
      q = q * 2 + qs;
    end
    return {q[7:0], rem[7:0]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: records each accepted command and its expected result.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) begin
        pending     <= 1'b1;
        acc         <= cyc + 1;
        {eq, er}    <= model(dividend, divisor, approx_mode);
`ifdef ADIV_OVF_CHECK_EN
        eovf        <= (dividend[15:8] >= divisor);
`else
        eovf        <= 1'b0;
`endif
      end else if (out_valid && out_ready) begin
        pending <= 1'b0;
      end
    end
  end

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({name, "_out_timeout"}, int'(out_valid), 1);
  endtask

  task automatic run_cmd(input logic [15:0] dd, input logic [7:0] dv, input logic [1:0] m,
                         output logic [7:0] q, output logic [7:0] r, output logic o);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_timeout", int'(in_ready), 1);
    in_valid    = 1'b1;
    dividend    = dd;
    divisor     = dv;
    approx_mode = m;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("cmd");
    q = quotient;
    r = remainder;
    o = ovf;
    @(negedge clk);
  endtask

  logic [7:0]  q, r;
  logic        o;
  logic [15:0] dd;
  logic [7:0]  dv;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          check("in_ready", int'(in_ready), int'(!pending));
          check("out_valid", int'(out_valid), int'(pending && (cyc - acc >= 8)));
          if (out_valid) begin
            check("quotient", int'(quotient), int'(eq));
            check("remainder", int'(remainder), int'(er));
            check("ovf", int'(ovf), int'(eovf));
          end
        end
      end
    join_none

    // Reset state (reset is asynchronous, so outputs are valid while held)
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    @(negedge clk);

    // Pin the model with hand-computed values
    check("model_1234_56", int'(model(16'h1234, 8'h56, 2'd0)), 16'h3610);
    check("model_0064_0a", int'(model(16'h0064, 8'h0A, 2'd0)), 16'h0A00);
    check("model_00ff_01_ad2", int'(model(16'h00FF, 8'h01, 2'd1)), 16'hFC02);
    check("model_div0", int'(model(16'h1234, 8'h00, 2'd0)), 16'hFF34);

    // Directed literal results
    run_cmd(16'h1234, 8'h56, 2'd0, q, r, o);
    check("exact_q", int'(q), 8'h36);
    check("exact_r", int'(r), 8'h10);
    check("exact_ovf", int'(o), 0);
    run_cmd(16'h00FF, 8'h01, 2'd1, q, r, o);
    check("ad2_q", int'(q), 8'hFC);
    check("ad2_r", int'(r), 8'h02);
    run_cmd(16'h1234, 8'h00, 2'd0, q, r, o);
    check("div0_q", int'(q), 8'hFF);
    check("div0_r", int'(r), 8'h34);

    // Backpressure with a second command waiting
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    dividend    = 16'h1234;
    divisor     = 8'h56;
    approx_mode = 2'd0;
    @(negedge clk);
    dividend = 16'h0064;
    divisor  = 8'h0A;
    wait_out("bp");
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_q", int'(quotient), 8'h36);
      check("bp_r", int'(remainder), 8'h10);
      check("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("bp2");
    check("bp2_q", int'(quotient), 8'h0A);
    check("bp2_r", int'(remainder), 8'h00);
    @(negedge clk);

    // Reset in the middle of an operation
    in_valid = 1'b1;
    dividend = 16'h1234;
    divisor  = 8'h56;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", int'(out_valid), 0);
    check("post_rst_in_ready", int'(in_ready), 1);
    run_cmd(16'h0064, 8'h0A, 2'd0, q, r, o);
    check("post_rst_q", int'(q), 8'h0A);
    check("post_rst_r", int'(r), 8'h00);

    // Overflow flag
    run_cmd(16'h0500, 8'h04, 2'd0, q, r, o);
`ifdef ADIV_OVF_CHECK_EN
    check("ovf_0500", int'(o), 1);
`else
    check("ovf_0500", int'(o), 0);
`endif
    run_cmd(16'h0300, 8'h04, 2'd0, q, r, o);
    check("ovf_0300", int'(o), 0);

    // Exact sweep against integer division
    for (int i = 0; i < 2000; i++) begin
      dv = 8'($urandom_range(1, 255));
      dd = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom_range(0, 255))};
      run_cmd(dd, dv, 2'd0, q, r, o);
      check("sweep_q", int'(q), int'(dd) / int'(dv));
      check("sweep_r", int'(r), int'(dd) % int'(dv));
    end

    // Approximate profiles and reserved mode, checked by the scoreboard
    for (int i = 0; i < 300; i++) begin
      run_cmd(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), 2'd1, q, r, o);
    end
    for (int i = 0; i < 100; i++) begin
      run_cmd(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), 2'd2, q, r, o);
    end
    for (int i = 0; i < 50; i++) begin
      run_cmd(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), 2'd3, q, r, o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
